// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: load/store unit over a req/gnt/rvalid data port.
// Holds EX/MEM while a request is pending and registers the MEM/WB outputs.
module mem_stage_lsu #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5,
  parameter int WB_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [2:0]        ctrl_mem_i,
  input  logic [2:0]        funct3_i,
  input  logic [WB_W-1:0]   ctrl_wb_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              zero_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [WB_W-1:0]   ctrl_wb_o,
  output logic [31:0]       alu_result_o,
  output logic [31:0]       read_data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              branch_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WGNT = 2'd1,
    S_WRV  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic       w_wr;
  logic       w_rd;
  logic       w_br;
  logic [1:0] w_size;
  logic       w_ill;
  logic       w_mis;
  logic       w_acc;
  logic       w_err;
  logic       w_memop;
  logic       w_st_gnt;
  logic [4:0] w_sh;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;
  logic [3:0] w_be;
  logic [31:0] w_wdata;

  assign w_wr   = ctrl_mem_i[2];
  assign w_rd   = ctrl_mem_i[1];
  assign w_br   = ctrl_mem_i[0];
  assign w_size = funct3_i[1:0];

  // Decode access legality: illegal width codes and misaligned H/W
  always_comb begin
    w_ill = 1'b0;
    if (w_wr)
      w_ill = (funct3_i >= 3'b011);
    else
      w_ill = (funct3_i == 3'b011) ||
              (funct3_i[2:1] == 2'b11);
    w_mis = ((w_size == 2'b01) && addr_i[0]) ||
            ((w_size == 2'b10) && (addr_i[1:0] != 2'b00));
    w_acc = in_valid_i && (w_wr || w_rd);
    w_err = w_acc && ((w_wr && w_rd) || w_ill || w_mis);
    w_memop  = w_acc && !w_err;
    w_st_gnt = w_wr && dmem_gnt_i;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          if (!dmem_gnt_i)
            w_next = S_WGNT;
          else if (!w_wr)
            w_next = S_WRV;
        end
      end
      S_WGNT: begin
        if (dmem_gnt_i)
          w_next = w_wr ? S_IDLE : S_WRV;
      end
      S_WRV: begin
        if (dmem_rvalid_i)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs: request and upstream stall
  always_comb begin
    dmem_req_o = 1'b0;
    stall_o    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        dmem_req_o = w_memop;
        stall_o    = w_memop && !w_st_gnt;
      end
      S_WGNT: begin
        dmem_req_o = 1'b1;
        stall_o    = !w_st_gnt;
      end
      S_WRV: begin
        stall_o = !dmem_rvalid_i;
      end
      default: begin
        dmem_req_o = 1'b0;
        stall_o    = 1'b0;
      end
    endcase
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    w_be    = 4'hF;
    w_wdata = wdata_i;
    unique case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {addr_i[1], 1'b0};
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = wdata_i;
      end
    endcase
  end

  assign dmem_we_o    = w_wr;
  assign dmem_be_o    = dmem_req_o ? w_be : 4'h0;
  assign dmem_wdata_o = w_wdata;
  assign dmem_addr_o  = {addr_i[ADDR_W-1:2], 2'b00};

  assign w_sh   = {addr_i[1:0], 3'b000};
  assign w_byte = 8'(dmem_rdata_i >> w_sh);
  assign w_half = 16'(dmem_rdata_i >> w_sh);

  // Load lane select and sign/zero extension
  always_comb begin
    w_ldata = dmem_rdata_i;
    unique case (funct3_i)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b100:  w_ldata = {24'h0, w_byte};
      3'b101:  w_ldata = {16'h0, w_half};
      default: w_ldata = dmem_rdata_i;
    endcase
  end

  // MEM/WB register: load on advance, bubble while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o   <= 1'b0;
      ctrl_wb_o    <= '0;
      alu_result_o <= '0;
      read_data_o  <= '0;
      rd_o         <= '0;
      branch_o     <= 1'b0;
      err_o        <= 1'b0;
    end else if (!stall_o) begin
      wb_valid_o   <= in_valid_i && !w_err;
      ctrl_wb_o    <= ctrl_wb_i;
      alu_result_o <= addr_i;
      read_data_o  <= (w_memop && w_rd) ? w_ldata : 32'h0;
      rd_o         <= rd_i;
      branch_o     <= in_valid_i && w_br && zero_i;
      err_o        <= w_err;
    end else begin
      wb_valid_o <= 1'b0;
      branch_o   <= 1'b0;
      err_o      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed table, reset corner, random vs model.
// Memory responses are scheduled per transaction (gnt delay, rvalid delay).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic [2:0]  ctrl_mem_i;
  logic [2:0]  funct3_i;
  logic [1:0]  ctrl_wb_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        zero_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [1:0]  ctrl_wb_o;
  logic [31:0] alu_result_o;
  logic [31:0] read_data_o;
  logic [4:0]  rd_o;
  logic        branch_o;
  logic        err_o;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .ctrl_mem_i(ctrl_mem_i),
    .funct3_i(funct3_i), .ctrl_wb_i(ctrl_wb_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .zero_i(zero_i), .rd_i(rd_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .ctrl_wb_o(ctrl_wb_o),
    .alu_result_o(alu_result_o), .read_data_o(read_data_o),
    .rd_o(rd_o), .branch_o(branch_o), .err_o(err_o)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  ctrl;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        zero;
    int          gd;
    int          rvd;
    logic [31:0] rdata;
    int          e_stall;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wbv;
    logic [31:0] e_rdo;
    logic        e_br;
    logic        e_err;
  } vec_t;

  int nvec = 0;
  int nfail = 0;
  int tid = 0;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL t%0d %s: got %h want %h", tid, nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic v, input logic [2:0] c, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] wd, input logic z,
    input int gd, input int rvd, input logic [31:0] rdt,
    input int es, input logic er, input logic [3:0] eb,
    input logic [31:0] ew, input logic ev, input logic [31:0] eo,
    input logic ebr, input logic ee);
    vec_t t;
    t.valid = v; t.ctrl = c; t.f3 = f; t.addr = a;
    t.wdata = wd; t.zero = z; t.gd = gd; t.rvd = rvd;
    t.rdata = rdt; t.e_stall = es; t.e_req = er; t.e_be = eb;
    t.e_wdata = ew; t.e_wbv = ev; t.e_rdo = eo;
    t.e_br = ebr; t.e_err = ee;
    return t;
  endfunction

  // Reference: expectations straight from the access rules
  function automatic vec_t model(input vec_t v);
    vec_t t = v;
    logic wr = v.ctrl[2];
    logic rdb = v.ctrl[1];
    int sz = int'(v.f3[1:0]);
    int off = int'(v.addr[1:0]);
    int f = int'(v.f3);
    logic acc, ill, mis;
    logic [31:0] w;
    acc = v.valid && (wr || rdb);
    ill = wr ? (f >= 3) : (f == 3 || f == 6 || f == 7);
    mis = (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
    t.e_err = acc && ((wr && rdb) || ill || mis);
    t.e_req = acc && !t.e_err;
    t.e_stall = !t.e_req ? 0 : (wr ? v.gd : v.gd + 1 + v.rvd);
    if (sz == 0) begin
      t.e_be = 4'(1 << off);
      t.e_wdata = 32'(v.wdata[7:0]) * 32'h01010101;
    end else if (sz == 1) begin
      t.e_be = 4'(3 << ((off / 2) * 2));
      t.e_wdata = 32'(v.wdata[15:0]) * 32'h00010001;
    end else begin
      t.e_be = 4'hF;
      t.e_wdata = v.wdata;
    end
    w = v.rdata >> (8 * off);
    t.e_rdo = 32'h0;
    if (t.e_req && !wr) begin
      case (f)
        0: t.e_rdo = {{24{w[7]}}, w[7:0]};
        1: t.e_rdo = {{16{w[15]}}, w[15:0]};
        4: t.e_rdo = {24'h0, w[7:0]};
        5: t.e_rdo = {16'h0, w[15:0]};
        default: t.e_rdo = v.rdata;
      endcase
    end
    t.e_wbv = v.valid && !t.e_err;
    t.e_br = v.valid && v.ctrl[0] && v.zero;
    return t;
  endfunction

  // Apply one instruction, play the memory, check each cycle
  task automatic run(input vec_t v);
    logic [4:0] rdi = 5'($urandom);
    logic [1:0] cwb = 2'($urandom);
    logic lt = v.e_req && !v.ctrl[2];
    logic hit;
    in_valid_i = v.valid; ctrl_mem_i = v.ctrl;
    funct3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
    zero_i = v.zero; rd_i = rdi; ctrl_wb_i = cwb;
    for (int k = 0; k <= v.e_stall; k++) begin
      hit = lt && (k == v.gd + 1 + v.rvd);
      dmem_gnt_i = v.e_req && (k == v.gd);
      if (hit)
        dmem_rvalid_i = 1'b1;
      else if (lt && k > v.gd)
        dmem_rvalid_i = 1'b0;
      else
        dmem_rvalid_i = 1'($urandom);
      dmem_rdata_i = hit ? v.rdata : $urandom;
      @(negedge clk);
      chk("stall", 32'(stall_o), 32'(k < v.e_stall));
      chk("req", 32'(dmem_req_o), 32'(v.e_req && k <= v.gd));
      if (v.e_req && k <= v.gd) begin
        chk("we", 32'(dmem_we_o), 32'(v.ctrl[2]));
        chk("addr", dmem_addr_o, {v.addr[31:2], 2'b00});
        if (v.ctrl[2]) begin
          chk("be", 32'(dmem_be_o), 32'(v.e_be));
          chk("wdata", dmem_wdata_o, v.e_wdata);
        end
      end
      @(posedge clk);
      #1;
      if (k < v.e_stall) begin
        chk("bub_wbv", 32'(wb_valid_o), 32'h0);
        chk("bub_err", 32'(err_o), 32'h0);
      end
    end
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    chk("wb_valid", 32'(wb_valid_o), 32'(v.e_wbv));
    chk("err", 32'(err_o), 32'(v.e_err));
    chk("branch", 32'(branch_o), 32'(v.e_br));
    chk("rdata_o", read_data_o, v.e_rdo);
    chk("alu", alu_result_o, v.addr);
    chk("rd", 32'(rd_o), 32'(rdi));
    chk("ctrl_wb", 32'(ctrl_wb_o), 32'(cwb));
    tid++;
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mkv(1, 3'b100, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0,
                  0, 1, 4'hF, 32'hDEADBEEF, 1, 0, 0, 0);
    tbl[1]  = mkv(1, 3'b010, 3'b000, 32'h103, 0, 0, 0, 1, 32'h80FFFF7F,
                  2, 1, 4'h0, 0, 1, 32'hFFFFFF80, 0, 0);
    tbl[2]  = mkv(1, 3'b010, 3'b100, 32'h103, 0, 0, 0, 1, 32'h80FFFF7F,
                  2, 1, 4'h0, 0, 1, 32'h00000080, 0, 0);
    tbl[3]  = mkv(1, 3'b100, 3'b001, 32'h102, 32'h1234, 0, 3, 0, 0,
                  3, 1, 4'b1100, 32'h12341234, 1, 0, 0, 0);
    tbl[4]  = mkv(1, 3'b010, 3'b010, 32'h101, 0, 0, 0, 0, 0,
                  0, 0, 4'h0, 0, 0, 0, 0, 1);
    tbl[5]  = mkv(1, 3'b001, 3'b000, 32'h0, 0, 1, 0, 0, 0,
                  0, 0, 4'h0, 0, 1, 0, 1, 0);
    tbl[6]  = mkv(0, 3'b001, 3'b000, 32'h0, 0, 1, 0, 0, 0,
                  0, 0, 4'h0, 0, 0, 0, 0, 0);
    tbl[7]  = mkv(1, 3'b010, 3'b001, 32'h102, 0, 0, 1, 0, 32'h80011234,
                  2, 1, 4'h0, 0, 1, 32'hFFFF8001, 0, 0);
    tbl[8]  = mkv(1, 3'b010, 3'b101, 32'h100, 0, 0, 0, 2, 32'h8001F234,
                  3, 1, 4'h0, 0, 1, 32'h0000F234, 0, 0);
    tbl[9]  = mkv(1, 3'b100, 3'b000, 32'h101, 32'h000000A5, 0, 1, 0, 0,
                  1, 1, 4'b0010, 32'hA5A5A5A5, 1, 0, 0, 0);
    tbl[10] = mkv(1, 3'b100, 3'b011, 32'h100, 32'h1, 0, 0, 0, 0,
                  0, 0, 4'h0, 0, 0, 0, 0, 1);
    tbl[11] = mkv(1, 3'b110, 3'b010, 32'h100, 32'h1, 0, 0, 0, 0,
                  0, 0, 4'h0, 0, 0, 0, 0, 1);
    tbl[12] = mkv(1, 3'b010, 3'b010, 32'h104, 0, 0, 2, 0, 32'h12345678,
                  3, 1, 4'h0, 0, 1, 32'h12345678, 0, 0);

    rst = 1'b1; in_valid_i = 1'b0; ctrl_mem_i = 3'b0;
    funct3_i = 3'b0; ctrl_wb_i = 2'b0; addr_i = 32'h0;
    wdata_i = 32'h0; zero_i = 1'b0; rd_i = 5'h0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wbv", 32'(wb_valid_o), 32'h0);
    chk("rst_rdo", read_data_o, 32'h0);
    chk("rst_alu", alu_result_o, 32'h0);
    chk("rst_br", 32'(branch_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run(tbl[i]);

    // Reset while waiting for rvalid; a late rvalid must be ignored
    in_valid_i = 1'b1; ctrl_mem_i = 3'b010; funct3_i = 3'b010;
    addr_i = 32'h200; rd_i = 5'd7; ctrl_wb_i = 2'b11;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("mr_stall0", 32'(stall_o), 32'h1);
    @(posedge clk);
    #1;
    dmem_gnt_i = 1'b0;
    @(negedge clk);
    chk("mr_stall1", 32'(stall_o), 32'h1);
    chk("mr_req1", 32'(dmem_req_o), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_wbv", 32'(wb_valid_o), 32'h0);
    chk("mr_alu", alu_result_o, 32'h0);
    chk("mr_rd", 32'(rd_o), 32'h0);
    chk("mr_cwb", 32'(ctrl_wb_o), 32'h0);
    rst = 1'b0;
    in_valid_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mr_stall2", 32'(stall_o), 32'h0);
    chk("mr_req2", 32'(dmem_req_o), 32'h0);
    @(posedge clk);
    #1;
    dmem_rvalid_i = 1'b0;
    chk("mr_rdo", read_data_o, 32'h0);
    chk("mr_wbv2", 32'(wb_valid_o), 32'h0);
    @(negedge clk);
    chk("mr_idle", 32'(stall_o), 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 200; i++) begin
      v.valid = ($urandom % 10) != 0;
      v.ctrl = 3'($urandom);
      v.f3 = 3'($urandom);
      v.addr = 32'h1000 + ($urandom % 256);
      v.wdata = $urandom;
      v.zero = 1'($urandom);
      v.gd = $urandom % 4;
      v.rvd = $urandom % 4;
      v.rdata = $urandom;
      run(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
